hazard_forward_scoreboard: RTL

HAZARD_FORWARD_SCOREBOARD -- requirements
Module: hazard_forward_scoreboard

---
 rtl/hazard_forward_scoreboard.sv | 108 ++++++++++
 1 files changed

// File: rtl/hazard_forward_scoreboard.sv
// ID-stage hazard unit: tracks in-flight destination registers and resolves
// each ID source to a forwarding select, or raises stall for load-use / no-forward cases.
module hazard_forward_scoreboard #(
  parameter int DATA_W           = 32,
  parameter int REG_ADDR_W       = 4,
  parameter int DEPTH            = 3,
  parameter int FWD_EN           = 1,
  parameter int LOAD_READY_STAGE = 1,
  localparam int SEL_W           = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic                    id_use_src1,
  input  logic                    id_has_two_src,
  input  logic [REG_ADDR_W-1:0]   id_src1,
  input  logic [REG_ADDR_W-1:0]   id_src2,
  input  logic [REG_ADDR_W-1:0]   id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_r_en,
  input  logic                    flush,
  input  logic [DEPTH*DATA_W-1:0] stage_result,
  output logic                    stall,
  output logic [SEL_W-1:0]        fwd_sel1,
  output logic [SEL_W-1:0]        fwd_sel2,
  output logic [DATA_W-1:0]       fwd_val1,
  output logic [DATA_W-1:0]       fwd_val2,
  output logic [15:0]             stall_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [DEPTH-1:0]      sb_vld;
  logic [DEPTH-1:0]      sb_wb;
  logic [DEPTH-1:0]      sb_mr;
  logic [REG_ADDR_W-1:0] sb_dest [DEPTH];

  logic              hit1, hit2, ld1, ld2, early1, early2, hz1, hz2, issue;
  logic [SEL_W-1:0]  cand1, cand2;
  logic [DATA_W-1:0] cval1, cval2;

  // Producer lookup: scan oldest to youngest so the lowest matching k wins.
  always_comb begin
    hit1 = 1'b0; ld1 = 1'b0; early1 = 1'b0; cand1 = '0; cval1 = '0;
    hit2 = 1'b0; ld2 = 1'b0; early2 = 1'b0; cand2 = '0; cval2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_vld[k] && sb_wb[k] && sb_dest[k] == id_src1) begin
        hit1   = 1'b1;
        ld1    = sb_mr[k];
        early1 = (k < LOAD_READY_STAGE);
        cand1  = SEL_W'(k + 1);
        cval1  = stage_result[k*DATA_W +: DATA_W];
      end
      if (sb_vld[k] && sb_wb[k] && sb_dest[k] == id_src2) begin
        hit2   = 1'b1;
        ld2    = sb_mr[k];
        early2 = (k < LOAD_READY_STAGE);
        cand2  = SEL_W'(k + 1);
        cval2  = stage_result[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    hz1      = id_use_src1 && hit1 && ((FWD_EN == 0) || (ld1 && early1));
    hz2      = id_has_two_src && hit2 && ((FWD_EN == 0) || (ld2 && early2));
    stall    = id_valid && !flush && (hz1 || hz2);
    issue    = id_valid && !flush && !stall;
    fwd_sel1 = '0;
    fwd_val1 = '0;
    fwd_sel2 = '0;
    fwd_val2 = '0;
    if (FWD_EN != 0 && id_use_src1 && hit1 && !hz1) begin
      fwd_sel1 = cand1;
      fwd_val1 = cval1;
    end
    if (FWD_EN != 0 && id_has_two_src && hit2 && !hz2) begin
      fwd_sel2 = cand2;
      fwd_val2 = cval2;
    end
  end

  // Scoreboard advance: control bits are reset, payload fields just follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_vld    <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) sb_vld[k] <= sb_vld[k-1];
      sb_vld[0] <= issue;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = DEPTH - 1; k > 0; k--) begin
      sb_dest[k] <= sb_dest[k-1];
      sb_wb[k]   <= sb_wb[k-1];
      sb_mr[k]   <= sb_mr[k-1];
    end
    sb_dest[0] <= id_dest;
    sb_wb[0]   <= id_wb_en;
    sb_mr[0]   <= id_mem_r_en;
  end

endmodule
